// File: rtl/pcpi_acc_pkg.sv
// Shared constants for the PCPI FIR estimator: decode values, FSM states and accumulator sizing.
package pcpi_acc_pkg;
  localparam logic [6:0] OPC_CUSTOM0 = 7'b0001011;

  localparam logic [1:0] F7_LOAD  = 2'd0;
  localparam logic [1:0] F7_PUSH  = 2'd1;
  localparam logic [1:0] F7_COMP  = 2'd2;
  localparam logic [1:0] F7_SETDS = 2'd3;

  typedef enum logic [2:0] {
    ST_IDLE, ST_EXEC, ST_ACC, ST_RESP, ST_GUARD
  } state_t;

  // Headroom for K*N full-scale terms plus the sign of a negated minimum value.
  function automatic int acc_w(input int wc, input int kn);
    return wc + $clog2(kn) + 1;
  endfunction
endpackage

// File: rtl/pcpi_acc_lane_sum.sv
// Combinational LANES-wide +/- adder: each coefficient is added or subtracted by its sign bit.
module pcpi_acc_lane_sum #(
  parameter int LANES = 16,
  parameter int WC    = 32,
  parameter int ACC_W = 43
) (
  input  logic [LANES-1:0][WC-1:0] i_coef,
  input  logic [LANES-1:0]         i_sgn,
  output logic signed [ACC_W-1:0]  o_sum
);
  logic [LANES-1:0][ACC_W-1:0] w_term;

  for (genvar l = 0; l < LANES; l++) begin : g_lane
    logic signed [ACC_W-1:0] w_ext;
    assign w_ext     = {{(ACC_W-WC){i_coef[l][WC-1]}}, i_coef[l]};
    assign w_term[l] = i_sgn[l] ? w_ext : -w_ext;
  end

  always_comb begin
    o_sum = '0;
    for (int l = 0; l < LANES; l++) o_sum = o_sum + signed'(w_term[l]);
  end
endmodule

// File: rtl/pcpi_fir_ds_acc.sv
// PicoRV32 PCPI FIR estimator with fused downsampling; multi-cycle LANES-wide accumulate.
// Define PCPI_ACC_SAT_EN to saturate the result to signed 32 bits instead of wrapping.
module pcpi_fir_ds_acc
  import pcpi_acc_pkg::*;
#(
  parameter int K                 = 128,
  parameter int N                 = 8,
  parameter int WIDTH_COEFFICIENT = 32,
  parameter int LANES             = 16,
  parameter int DS_W              = 8
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic        pcpi_valid,
  input  logic [31:0] pcpi_insn,
  input  logic [31:0] pcpi_rs1,
  input  logic [31:0] pcpi_rs2,
  output logic        pcpi_wr,
  output logic [31:0] pcpi_rd,
  output logic        pcpi_wait,
  output logic        pcpi_ready,
  output logic        busy
);
  localparam int WC    = WIDTH_COEFFICIENT;
  localparam int KN    = K * N;
  localparam int C     = KN / LANES;
  localparam int ACC_W = acc_w(WC, KN);
  localparam int KNW   = (KN > 1) ? $clog2(KN) : 1;
  localparam int CW    = (C > 1) ? $clog2(C) : 1;

  state_t                  r_state, w_next;
  logic [1:0]              r_op;
  logic [31:0]             r_rs1, r_rs2;
  logic [KN-1:0][WC-1:0]   r_coef;
  logic [K-1:0][N-1:0]     r_hist;
  logic [DS_W-1:0]         r_ds, r_pcnt;
  logic [CW-1:0]           r_cnt;
  logic signed [ACC_W-1:0] r_acc;
  logic                    r_wr;

  logic                    w_claim, w_ds_hit, w_need_acc;
  logic [KN-1:0]           w_sflat;
  logic [LANES-1:0][WC-1:0] w_lane_coef;
  logic [LANES-1:0]        w_lane_sgn;
  logic signed [ACC_W-1:0] w_lane_sum;
  logic [31:0]             w_res;

  assign w_claim    = (pcpi_insn[6:0] == OPC_CUSTOM0) && (pcpi_insn[14:12] == 3'd0)
                   && (pcpi_insn[31:27] == 5'd0);
  assign w_ds_hit   = (r_pcnt + DS_W'(1)) == r_ds;
  assign w_need_acc = (r_op == F7_COMP) || ((r_op == F7_PUSH) && w_ds_hit);
  // Flattened history: bit k*N+n is s[k][n], matching coefficient index i.
  assign w_sflat    = r_hist;

  always_comb begin
    w_lane_coef = '0;
    w_lane_sgn  = '0;
    for (int l = 0; l < LANES; l++) begin
      w_lane_coef[l] = r_coef[KNW'(int'(r_cnt) * LANES + l)];
      w_lane_sgn[l]  = w_sflat[KNW'(int'(r_cnt) * LANES + l)];
    end
  end

  pcpi_acc_lane_sum #(.LANES(LANES), .WC(WC), .ACC_W(ACC_W)) u_lane_sum (
    .i_coef (w_lane_coef),
    .i_sgn  (w_lane_sgn),
    .o_sum  (w_lane_sum)
  );

`ifdef PCPI_ACC_SAT_EN
  logic signed [63:0] w_wide;
  assign w_wide = 64'(r_acc);
  always_comb begin
    if (w_wide > 64'sh0000_0000_7FFF_FFFF)      w_res = 32'h7FFF_FFFF;
    else if (w_wide < 64'shFFFF_FFFF_8000_0000) w_res = 32'h8000_0000;
    else                                        w_res = w_wide[31:0];
  end
`else
  assign w_res = 32'(r_acc);
`endif

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) r_state <= ST_IDLE;
    else         r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      ST_IDLE:  if (pcpi_valid && w_claim) w_next = ST_EXEC;
      ST_EXEC:  w_next = w_need_acc ? ST_ACC : ST_RESP;
      ST_ACC:   if (r_cnt == CW'(C - 1)) w_next = ST_RESP;
      ST_RESP:  w_next = ST_GUARD;
      ST_GUARD: w_next = ST_IDLE;
      default:  w_next = ST_IDLE;
    endcase
  end

  always_comb begin
    pcpi_wait  = (r_state == ST_EXEC) || (r_state == ST_ACC);
    pcpi_ready = (r_state == ST_RESP);
    pcpi_wr    = pcpi_ready && r_wr;
    pcpi_rd    = pcpi_wr ? w_res : '0;
    busy       = (r_state != ST_IDLE);
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_op   <= '0;
      r_rs1  <= '0;
      r_rs2  <= '0;
      r_coef <= '0;
      r_hist <= '0;
      r_ds   <= DS_W'(1);
      r_pcnt <= '0;
      r_cnt  <= '0;
      r_acc  <= '0;
      r_wr   <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: if (pcpi_valid && w_claim) begin
          r_op  <= pcpi_insn[26:25];
          r_rs1 <= pcpi_rs1;
          r_rs2 <= pcpi_rs2;
        end
        ST_EXEC: begin
          r_wr  <= w_need_acc;
          r_acc <= '0;
          r_cnt <= '0;
          case (r_op)
            F7_LOAD:  if (r_rs1 < KN) r_coef[r_rs1[KNW-1:0]] <= r_rs2[WC-1:0];
            F7_PUSH: begin
              r_hist <= {r_hist[K-2:0], r_rs1[N-1:0]};
              r_pcnt <= w_ds_hit ? '0 : r_pcnt + DS_W'(1);
            end
            F7_SETDS: begin
              r_ds   <= (r_rs1[DS_W-1:0] == '0) ? DS_W'(1) : r_rs1[DS_W-1:0];
              r_pcnt <= '0;
            end
            default: ;
          endcase
        end
        ST_ACC: begin
          r_acc <= r_acc + w_lane_sum;
          r_cnt <= r_cnt + CW'(1);
        end
        default: ;
      endcase
    end
  end
endmodule

// File: tb/tb_pcpi_fir_ds_acc.sv
// Directed bench for pcpi_fir_ds_acc (K=4, N=2, LANES=2) against a plain-arithmetic model.
module tb_pcpi_fir_ds_acc;
  localparam int K = 4, N = 2, WC = 32, LANES = 2, DS_W = 8;
  localparam int C = K * N / LANES;

  logic        clk = 1'b0;
  logic        resetn;
  logic        pcpi_valid;
  logic [31:0] pcpi_insn, pcpi_rs1, pcpi_rs2;
  logic        pcpi_wr, pcpi_wait, pcpi_ready, busy;
  logic [31:0] pcpi_rd;

  always #5 clk = ~clk;

  pcpi_fir_ds_acc #(.K(K), .N(N), .WIDTH_COEFFICIENT(WC), .LANES(LANES), .DS_W(DS_W)) dut (
    .clk(clk), .resetn(resetn), .pcpi_valid(pcpi_valid), .pcpi_insn(pcpi_insn),
    .pcpi_rs1(pcpi_rs1), .pcpi_rs2(pcpi_rs2), .pcpi_wr(pcpi_wr), .pcpi_rd(pcpi_rd),
    .pcpi_wait(pcpi_wait), .pcpi_ready(pcpi_ready), .busy(busy)
  );

  int          checks = 0, errors = 0;
  int          issue_cnt = 0, resp_cnt = 0, lat = 0, wcnt = 0;
  logic        exp_wr = 1'b0;
  logic [31:0] exp_rd = '0;
  int          exp_lat = 0, exp_wait = 0;
  logic        noclaim = 1'b0;

  // Model state
  longint m_coef[K*N];
  int     m_hist[K];
  int     m_d, m_cnt;

  function automatic logic [31:0] mres();
    longint s;
    s = 0;
    for (int i = 0; i < K*N; i++)
      if (((m_hist[i/N] >> (i%N)) & 1) != 0) s += m_coef[i];
      else                                   s -= m_coef[i];
`ifdef PCPI_ACC_SAT_EN
    if (s > 64'sh7FFFFFFF) s = 64'sh7FFFFFFF;
    else if (s < -64'sh80000000) s = -64'sh80000000;
`endif
    return s[31:0];
  endfunction

  task automatic m_reset();
    for (int i = 0; i < K*N; i++) m_coef[i] = 0;
    for (int k = 0; k < K; k++) m_hist[k] = 0;
    m_d = 1;
    m_cnt = 0;
  endtask

  // Single checker: outputs in reset, response contents, latency, wait length, spurious handshakes.
  always @(negedge clk) begin
    if (!resetn) begin
      checks++;
      if ({pcpi_wr, pcpi_wait, pcpi_ready, busy} != 4'b0 || pcpi_rd != 32'd0) begin
        errors++;
        $display("FAIL reset_outputs: wr=%0b wait=%0b ready=%0b busy=%0b rd=%h, required all zero",
                 pcpi_wr, pcpi_wait, pcpi_ready, busy, pcpi_rd);
      end
      resp_cnt = issue_cnt;
      lat = 0;
      wcnt = 0;
    end else begin
      checks++;
      if ((!pcpi_wr && pcpi_rd != 32'd0) || (pcpi_wr && !pcpi_ready)) begin
        errors++;
        $display("FAIL rd_qualify: wr=%0b ready=%0b rd=%h, required rd=0 unless wr, wr only with ready",
                 pcpi_wr, pcpi_ready, pcpi_rd);
      end
      if (issue_cnt != resp_cnt) begin
        lat++;
        if (pcpi_wait) wcnt++;
        if (pcpi_ready) begin
          checks += 4;
          if (pcpi_wr !== exp_wr) begin
            errors++; $display("FAIL resp_wr: got %0b expected %0b", pcpi_wr, exp_wr);
          end
          if (pcpi_rd !== exp_rd) begin
            errors++; $display("FAIL resp_rd: got %h expected %h", pcpi_rd, exp_rd);
          end
          if (lat - 1 != exp_lat) begin
            errors++; $display("FAIL latency: got %0d expected %0d", lat - 1, exp_lat);
          end
          if (wcnt != exp_wait) begin
            errors++; $display("FAIL wait_cycles: got %0d expected %0d", wcnt, exp_wait);
          end
          resp_cnt = issue_cnt; lat = 0; wcnt = 0;
        end else if (lat > 40) begin
          checks++; errors++;
          $display("FAIL timeout: no ready after %0d cycles, expected within %0d", lat, exp_lat);
          resp_cnt = issue_cnt; lat = 0; wcnt = 0;
        end
      end else begin
        checks++;
        if (pcpi_ready || (noclaim && (pcpi_wait || busy))) begin
          errors++;
          $display("FAIL spurious: ready=%0b wait=%0b busy=%0b with no claimed op, expected 0",
                   pcpi_ready, pcpi_wait, busy);
        end
      end
    end
  end

  // Issue one claimed instruction and hold valid until one edge past ready, like the CPU.
  task automatic op(input logic [6:0] f7, input logic [31:0] a, input logic [31:0] b,
                    input logic ew, input logic [31:0] erd, input int el);
    exp_wr = ew; exp_rd = erd; exp_lat = el; exp_wait = el - 1;
    pcpi_insn  = {f7, 10'd0, 3'd0, 5'd0, 7'b0001011};
    pcpi_rs1   = a;
    pcpi_rs2   = b;
    pcpi_valid = 1'b1;
    issue_cnt++;
    for (int i = 0; i < 60 && resp_cnt != issue_cnt; i++) @(posedge clk);
    #1 pcpi_valid = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic load(input logic [31:0] i, input logic [31:0] v);
    if (i < K*N) m_coef[i] = longint'($signed(v));
    op(7'd0, i, v, 1'b0, 32'd0, 2);
  endtask

  task automatic push(input logic [31:0] s);
    for (int k = K - 1; k > 0; k--) m_hist[k] = m_hist[k-1];
    m_hist[0] = int'(s[N-1:0]);
    m_cnt++;
    if (m_cnt == m_d) begin
      m_cnt = 0;
      op(7'd1, s, 32'd0, 1'b1, mres(), C + 2);
    end else op(7'd1, s, 32'd0, 1'b0, 32'd0, 2);
  endtask

  task automatic compute();
    op(7'd2, 32'd0, 32'd0, 1'b1, mres(), C + 2);
  endtask

  task automatic compute_lit(input logic [31:0] e);
    op(7'd2, 32'd0, 32'd0, 1'b1, e, C + 2);
  endtask

  task automatic setds(input logic [31:0] v);
    m_d = (v[DS_W-1:0] == '0) ? 1 : int'(v[DS_W-1:0]);
    m_cnt = 0;
    op(7'd3, v, 32'd0, 1'b0, 32'd0, 2);
  endtask

  task automatic idle_insn(input logic [31:0] insn, input int cycles);
    noclaim = 1'b1;
    pcpi_insn = insn; pcpi_valid = 1'b1;
    repeat (cycles) @(posedge clk);
    #1 pcpi_valid = 1'b0;
    @(posedge clk); #1 noclaim = 1'b0;
  endtask

  initial begin
    #1000000;
    $display("FAIL global_timeout: bench did not finish");
    $fatal(1);
  end

  initial begin
    pcpi_valid = 1'b0; pcpi_insn = '0; pcpi_rs1 = '0; pcpi_rs2 = '0;
    resetn = 1'b1;
    m_reset();
    #1 resetn = 1'b0;
    repeat (3) @(posedge clk);
    #1 resetn = 1'b1;

    compute_lit(32'd0);

    for (int i = 0; i < K*N; i++) load(32'(i), 32'(i + 1));
    repeat (4) push(32'd3);
    compute_lit(32'h0000_0024);

    repeat (4) push(32'd0);
    compute_lit(32'hFFFF_FFDC);

    push(32'd1); push(32'd2); compute();

    setds(32'd2);
    push(32'd3);
    push(32'd3);
    setds(32'd0);
    push(32'd1);
    push(32'd2);

    load(32'd8, 32'hDEAD_BEEF);
    compute();
    idle_insn({7'd5, 10'd0, 3'd0, 5'd0, 7'b0001011}, 20);
    idle_insn({7'd2, 10'd0, 3'd1, 5'd0, 7'b0001011}, 5);
    idle_insn({7'd2, 10'd0, 3'd0, 5'd0, 7'b0110011}, 5);

    for (int i = 0; i < K*N; i++) load(32'(i), 32'h7FFF_FFFF);
    repeat (4) push(32'd3);
`ifdef PCPI_ACC_SAT_EN
    compute_lit(32'h7FFF_FFFF);
`else
    compute_lit(32'hFFFF_FFF8);
`endif

    // Abort a compute in its second accumulate cycle.
    setds(32'd3);
    push(32'd3);
    pcpi_insn  = {7'd2, 10'd0, 3'd0, 5'd0, 7'b0001011};
    pcpi_valid = 1'b1;
    issue_cnt++;
    repeat (3) @(posedge clk);
    #1 resetn = 1'b0; pcpi_valid = 1'b0;
    m_reset();
    repeat (2) @(posedge clk);
    #1 resetn = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    push(32'd3);
    load(32'd6, 32'd5);
    compute();
    load(32'd0, 32'd9);
    compute();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
